ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_sync.sv | 38 +++
 rtl/ps2_host_tx.sv | 235 +++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and default timing for the PS/2 host transmitter.
package ps2_pkg;

    // Host-to-device transmit sequence.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SEND      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } ps2_state_t;

    // Defaults for a 100 MHz system clock.
    localparam int PS2_INHIBIT_CYCLES = 10000;    // 100 us clock inhibit
    localparam int PS2_REQ_CYCLES     = 20;       // data low before clock release
    localparam int PS2_TIMEOUT_CYCLES = 1500000;  // 15 ms device watchdog

    // Width for a counter that counts 0 .. n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for one PS/2 pad plus a falling-edge strobe.
// Both stages reset to 1, which is the idle level of an open-drain line.
module ps2_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic sync_o,
    output logic fall_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // Next values: shift the raw pad through the chain.
    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Synchronizer and edge-history flops, idle-high after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (open-drain, device-clocked).
//
// Handshake: a byte is accepted on a clk edge where tx_valid and tx_ready
// are both 1; tx_ready is high only while idle, and tx_valid at any other
// time is ignored. Completion is reported by a one-cycle tx_done (device
// acked) or tx_err (missing ack or watchdog) pulse, never both; tx_ready
// comes back the cycle after the pulse.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int REQ_CYCLES     = PS2_REQ_CYCLES,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       rx_inhibit,
    output ps2_state_t dbg_state
);

    localparam int INH_W = cnt_width(INHIBIT_CYCLES);
    localparam int REQ_W = cnt_width(REQ_CYCLES);
    localparam int TMO_W = cnt_width(TIMEOUT_CYCLES);

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [REQ_W-1:0] REQ_LAST = REQ_W'(REQ_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic clk_sync, clk_fall;
    logic data_sync, data_fall_unused;

    ps2_sync u_sync_clk (
        .clk    (clk),
        .rst    (rst),
        .d_i    (ps2_clk_i),
        .sync_o (clk_sync),
        .fall_o (clk_fall)
    );

    ps2_sync u_sync_data (
        .clk    (clk),
        .rst    (rst),
        .d_i    (ps2_data_i),
        .sync_o (data_sync),
        .fall_o (data_fall_unused)
    );

    ps2_state_t       state_q, state_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [REQ_W-1:0] req_cnt_q, req_cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             tx_ready_q, tx_ready_d;
    logic             tx_done_q, tx_done_d;
    logic             tx_err_q, tx_err_d;
    logic             rx_inhibit_q, rx_inhibit_d;

    // Next-state and next-output logic for the transmit sequence.
    always_comb begin
        state_d    = state_q;
        inh_cnt_d  = inh_cnt_q;
        req_cnt_d  = req_cnt_q;
        tmo_d      = tmo_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        clk_oe_d   = clk_oe_q;
        data_oe_d  = data_oe_q;
        tx_ready_d = 1'b0;
        tx_done_d  = 1'b0;
        tx_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                clk_oe_d   = 1'b0;
                data_oe_d  = 1'b0;
                tx_ready_d = 1'b1;
                if (tx_valid && tx_ready_q) begin
                    shift_d    = tx_data;
                    parity_d   = ~^tx_data;
                    inh_cnt_d  = '0;
                    req_cnt_d  = '0;
                    tmo_d      = '0;
                    bit_cnt_d  = '0;
                    clk_oe_d   = 1'b1;
                    tx_ready_d = 1'b0;
                    state_d    = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    data_oe_d = 1'b1;  // start bit
                    req_cnt_d = '0;
                    state_d   = ST_REQ;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end

            ST_REQ: begin
                if (req_cnt_q == REQ_LAST) begin
                    clk_oe_d  = 1'b0;  // hand the clock to the device
                    tmo_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = ST_SEND;
                end else begin
                    req_cnt_d = req_cnt_q + 1'b1;
                end
            end

            ST_SEND: begin
                if (clk_fall) begin
                    tmo_d     = '0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q < 4'd8) begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end else if (bit_cnt_q == 4'd8) begin
                        data_oe_d = ~parity_q;
                    end else begin
                        data_oe_d = 1'b0;  // stop bit is the released line
                        state_d   = ST_ACK;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    tx_err_d  = 1'b1;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            ST_ACK: begin
                if (clk_fall) begin
                    tmo_d     = '0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (!data_sync) begin
                        state_d = ST_WAIT_IDLE;
                    end else begin
                        tx_err_d = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    tx_err_d  = 1'b1;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            ST_WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    tx_done_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (clk_fall) begin
                    tmo_d = '0;
                end else if (tmo_q == TMO_LAST) begin
                    tx_err_d  = 1'b1;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        rx_inhibit_d = (state_d != ST_IDLE);
    end

    // State, datapath and registered outputs; reset releases both lines at once.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            inh_cnt_q    <= '0;
            req_cnt_q    <= '0;
            tmo_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            clk_oe_q     <= 1'b0;
            data_oe_q    <= 1'b0;
            tx_ready_q   <= 1'b1;
            tx_done_q    <= 1'b0;
            tx_err_q     <= 1'b0;
            rx_inhibit_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            inh_cnt_q    <= inh_cnt_d;
            req_cnt_q    <= req_cnt_d;
            tmo_q        <= tmo_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            clk_oe_q     <= clk_oe_d;
            data_oe_q    <= data_oe_d;
            tx_ready_q   <= tx_ready_d;
            tx_done_q    <= tx_done_d;
            tx_err_q     <= tx_err_d;
            rx_inhibit_q <= rx_inhibit_d;
        end
    end

    assign tx_ready    = tx_ready_q;
    assign tx_done     = tx_done_q;
    assign tx_err      = tx_err_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign rx_inhibit  = rx_inhibit_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on the
// open-drain lines (800-cycle device clock period).
module tb_ps2_host_tx;
  import ps2_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_done, tx_err;
  logic       ps2_clk_oe, ps2_data_oe, rx_inhibit;
  ps2_state_t dbg_state;

  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2_clk_line, ps2_data_line;
  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (100),
    .REQ_CYCLES     (20),
    .TIMEOUT_CYCLES (2000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .ps2_clk_i   (ps2_clk_line),
    .ps2_data_i  (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .rx_inhibit  (rx_inhibit),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass = 0;

  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int acc_cnt = 0;
  int acc_cycle = 0;
  int done_cycle = 0;
  int acc_at_done = 0;
  int rel_cycle = 0;
  int err_cycle = 0;
  int inh_len = 0;
  int inh_run = 0;
  logic prev_ready = 1'b1;
  logic prev_clk_oe = 1'b0;

  // Monitor: pulse counts, accept events, clock-hold length and release time.
  always @(negedge clk) begin
    cyc++;
    if (tx_done) begin
      done_cnt++;
      done_cycle = cyc;
      acc_at_done = acc_cnt;
    end
    if (tx_err) begin
      err_cnt++;
      err_cycle = cyc;
    end
    if (tx_done && tx_err) both_cnt++;
    if (prev_ready && !tx_ready) begin
      acc_cnt++;
      acc_cycle = cyc;
    end
    if (ps2_clk_oe) begin
      inh_run++;
    end else if (inh_run > 0) begin
      inh_len = inh_run;
      inh_run = 0;
    end
    if (prev_clk_oe && !ps2_clk_oe) rel_cycle = cyc;
    prev_ready  = tx_ready;
    prev_clk_oe = ps2_clk_oe;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] d, input bit keep_valid);
    int k;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (tx_ready && k < 10);
    check("accept_ready_low", {31'd0, tx_ready}, 32'd0);
    check("accept_rx_inhibit", {31'd0, rx_inhibit}, 32'd1);
    if (!keep_valid) tx_valid = 1'b0;
  endtask

  // Device: waits for request-to-send, clocks nclk bits, samples data at
  // each clock release. An 11th clock carries the ack (if ack is set).
  task automatic dev_run(input bit ack, input int nclk, output logic [9:0] bits);
    int k;
    bits = '0;
    k = 0;
    while (!(ps2_clk_line && !ps2_data_line) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("rts_lines", {30'd0, ps2_clk_line, ps2_data_line}, 32'b10);
    if (k >= 5000) return;
    repeat (200) @(negedge clk);
    for (int i = 0; i < nclk && i < 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (400) @(negedge clk);
      bits[i] = ps2_data_line;
      dev_clk_low = 1'b0;
      repeat (400) @(negedge clk);
    end
    if (nclk > 10) begin
      if (ack) dev_data_low = 1'b1;
      repeat (100) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (400) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (100) @(negedge clk);
      dev_data_low = 1'b0;
      repeat (20) @(negedge clk);
    end
  endtask

  task automatic wait_result(input int budget, input int snap);
    int k;
    k = 0;
    while ((done_cnt + err_cnt) == snap && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("result_seen", {31'd0, (done_cnt + err_cnt) != snap}, 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, {31'd0, tx_ready}, 32'd1);
    check({tag, "_oe"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check({tag, "_rx_inhibit"}, {31'd0, rx_inhibit}, 32'd0);
  endtask

  // Full transfer with expected {stop, parity, data[7:0]} as seen by the device.
  task automatic do_transfer(input string tag, input logic [7:0] d, input logic [9:0] exp_bits,
                             input bit ack);
    logic [9:0] bits;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(d, 1'b0);
    dev_run(ack, 11, bits);
    wait_result(3000, d0 + e0);
    repeat (2) @(negedge clk);
    check({tag, "_bits"}, {22'd0, bits}, {22'd0, exp_bits});
    check({tag, "_done"}, done_cnt - d0, ack ? 32'd1 : 32'd0);
    check({tag, "_err"}, err_cnt - e0, ack ? 32'd0 : 32'd1);
    check_idle(tag);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [9:0] bits;
    int d0, e0, a0;

    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_idle("reset");
    check("reset_pulses", {30'd0, tx_done, tx_err}, 32'd0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));

    // 0xF4: bits LSB first 0,0,1,0,1,1,1,1, parity 0, stop 1.
    do_transfer("f4", 8'hF4, 10'b1_0_1111_0100, 1'b1);
    check("f4_clock_hold", inh_len, 32'd120);
    do_transfer("ff", 8'hFF, 10'b1_1_1111_1111, 1'b1);
    do_transfer("zero", 8'h00, 10'b1_1_0000_0000, 1'b1);

    // Device never clocks: watchdog fires 2000 cycles after clock release.
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'hF4, 1'b0);
    wait_result(5000, d0 + e0);
    repeat (2) @(negedge clk);
    check("tmo_err", err_cnt - e0, 32'd1);
    check("tmo_done", done_cnt - d0, 32'd0);
    check("tmo_latency", err_cycle - rel_cycle, 32'd2000);
    check_idle("tmo");

    // Device leaves data high on the 11th clock: missing ack.
    do_transfer("noack", 8'hF4, 10'b1_0_1111_0100, 1'b0);

    // Reset mid-byte: after 4 device clocks bit 3 (0) is driven low.
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'hF4, 1'b0);
    dev_run(1'b1, 4, bits);
    check("midrst_pre_data_oe", {31'd0, ps2_data_oe}, 32'd1);
    check("midrst_pre_state", 32'(dbg_state), 32'(ST_SEND));
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("midrst_ready", {31'd0, tx_ready}, 32'd1);
    repeat (50) @(negedge clk);
    check("midrst_no_pulse", (err_cnt - e0) + (done_cnt - d0), 32'd0);
    do_transfer("after_rst", 8'hF4, 10'b1_0_1111_0100, 1'b1);

    // tx_valid held with changing data: 0xF4 first, 0x5A only after tx_done.
    d0 = done_cnt;
    e0 = err_cnt;
    a0 = acc_cnt;
    send_byte(8'hF4, 1'b1);
    tx_data = 8'h5A;
    dev_run(1'b1, 11, bits);
    wait_result(3000, d0 + e0);
    check("held_first_bits", {22'd0, bits}, {22'd0, 10'b1_0_1111_0100});
    check("held_accepts_at_done", acc_at_done - a0, 32'd1);
    check("held_second_after_done", acc_cycle - done_cycle, 32'd2);
    tx_valid = 1'b0;
    d0 = done_cnt;
    e0 = err_cnt;
    dev_run(1'b1, 11, bits);
    wait_result(3000, d0 + e0);
    repeat (2) @(negedge clk);
    check("held_second_bits", {22'd0, bits}, {22'd0, 10'b1_1_0101_1010});
    check("held_second_done", done_cnt - d0, 32'd1);
    check("held_total_accepts", acc_cnt - a0, 32'd2);
    check_idle("held");

    check("never_both", both_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog against a hung run.
  initial begin
    #2000000;
    $display("FAIL watchdog: got cycle %0d expected finish before 200000", cyc);
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

endmodule
